// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU-to-memory bus controller.
package cpu_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } bus_state_e;

  localparam logic BUS_READ  = 1'b0;
  localparam logic BUS_WRITE = 1'b1;

  // Value returned to the control unit when a read times out.
  localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 32'h0000_0000;

  typedef struct packed {
    logic              mode;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_txn_t;

  // Wait counter width; a disabled timeout still needs one bit.
  function automatic int unsigned wait_cnt_width(input int unsigned timeout);
    return (timeout == 32'd0) ? 32'd1 : 32'($clog2(timeout + 32'd1));
  endfunction

endpackage

// File: rtl/bus_controller_if.sv
// Memory-side request/acknowledge bus between the controller and the word memory.
interface bus_controller_if;
  import cpu_bus_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/bus_wait_counter.sv
// Clear/enable saturating wait counter with a registered terminal-count flag.
module bus_wait_counter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned   CW      = wait_cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_TC  = CW'(TIMEOUT);
  localparam logic          TC_EN   = (TIMEOUT != 32'd0);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tc_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Terminal count is computed from the next value so it lines up with cnt_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= TC_EN && (cnt_d == CNT_TC);
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/bus_controller.sv
// Single-outstanding read/write bridge from the CPU control unit to word memory,
// with misalignment detection and an acknowledge timeout.
module bus_controller
  import cpu_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_transaction,
  input  logic                mode,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                rdata_valid,
  output logic                write_done,
  output logic                bus_error,
  output logic                busy,
  bus_controller_if.master    bus
);

  bus_state_e        state_q, state_d;
  bus_txn_t          txn_q, txn_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic rdata_valid_q, rdata_valid_d;
  logic write_done_q, write_done_d;
  logic bus_error_q, bus_error_d;
  logic busy_q, busy_d;
  logic mem_req_q, mem_req_d;
  logic mem_we_q, mem_we_d;

  logic cnt_clr_c, cnt_en_c, cnt_tc;

  bus_wait_counter #(.TIMEOUT(TIMEOUT)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr_c),
    .en_i  (cnt_en_c),
    .tc_o  (cnt_tc)
  );

  // State, transaction latches and all outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      txn_q         <= '0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      write_done_q  <= 1'b0;
      bus_error_q   <= 1'b0;
      busy_q        <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      txn_q         <= txn_d;
      err_q         <= err_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      write_done_q  <= write_done_d;
      bus_error_q   <= bus_error_d;
      busy_q        <= busy_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    txn_d     = txn_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    cnt_clr_c = 1'b0;
    cnt_en_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_transaction) begin
          txn_d.mode  = mode;
          txn_d.addr  = {addr[ADDR_W-1:2], 2'b00};
          txn_d.wdata = wdata;
          err_d       = (addr[1:0] != 2'b00);
          cnt_clr_c   = 1'b1;
          state_d     = err_d ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.mem_ack) begin
          if (txn_q.mode == BUS_READ) rdata_d = bus.mem_rdata;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          cnt_en_c = 1'b1;
          // Acknowledge in the terminal cycle still wins over the timeout.
          if (cnt_tc) begin
            if (txn_q.mode == BUS_READ) rdata_d = TIMEOUT_RDATA;
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state only.
  always_comb begin
    busy_d        = (state_d != ST_IDLE);
    mem_req_d     = (state_d == ST_REQ);
    mem_we_d      = mem_req_d && (txn_d.mode == BUS_WRITE);
    rdata_valid_d = (state_d == ST_DONE) && (txn_d.mode == BUS_READ);
    write_done_d  = (state_d == ST_DONE) && (txn_d.mode == BUS_WRITE);
    bus_error_d   = (state_d == ST_DONE) && err_d;
  end

  assign rdata         = rdata_q;
  assign rdata_valid   = rdata_valid_q;
  assign write_done    = write_done_q;
  assign bus_error     = bus_error_q;
  assign busy          = busy_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = txn_q.addr;
  assign bus.mem_wdata = txn_q.wdata;

endmodule

// File: tb/tb_bus_controller.sv
// Self-checking bench for bus_controller: vector table with a completion scoreboard,
// plus hand-written back-to-back and mid-transaction reset sequences.
module tb_bus_controller;
  import cpu_bus_pkg::*;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_transaction;
  logic        mode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        write_done;
  logic        bus_error;
  logic        busy;

  bus_controller_if bif();

  bus_controller #(.TIMEOUT(TO)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start_transaction (start_transaction),
    .mode              (mode),
    .addr              (addr),
    .wdata             (wdata),
    .rdata             (rdata),
    .rdata_valid       (rdata_valid),
    .write_done        (write_done),
    .bus_error         (bus_error),
    .busy              (busy),
    .bus               (bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        md;
    logic [31:0] a;
    logic [31:0] wd;
    int          waits;
    logic        ack_en;
    logic [31:0] mrd;
    logic        exp_err;
    int          exp_lat;
    int          exp_req;
  } vec_t;

  typedef struct {
    logic        md;
    logic        err;
    logic [31:0] rd;
    int          lat;
    int          req;
  } exp_t;

  exp_t        sb_q[$];
  vec_t        vecs[8];
  logic [31:0] rdata_model;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input vec_t v);
    exp_t e;
    exp_t got;
    int   cyc;
    int   req_n;
    bit   done;
    e.md  = v.md;
    e.err = v.exp_err;
    e.lat = v.exp_lat;
    e.req = v.exp_req;
    if (v.md == BUS_READ) begin
      if (v.a[1:0] != 2'b00)  e.rd = rdata_model;
      else if (v.exp_err)     e.rd = 32'h0000_0000;
      else                    e.rd = v.mrd;
      rdata_model = e.rd;
    end else begin
      e.rd = rdata_model;
    end
    sb_q.push_back(e);

    start_transaction = 1'b1;
    mode  = v.md;
    addr  = v.a;
    wdata = v.wd;
    step();
    start_transaction = 1'b0;
    cyc   = 1;
    req_n = 0;
    done  = 1'b0;
    while (!done && cyc <= 20) begin
      if (bif.mem_req) begin
        req_n++;
        check("req_mem_we",    32'(bif.mem_we), 32'(v.md));
        check("req_mem_addr",  bif.mem_addr,    {v.a[31:2], 2'b00});
        check("req_mem_wdata", bif.mem_wdata,   v.wd);
        bif.mem_ack   = v.ack_en && (req_n == v.waits + 1);
        bif.mem_rdata = v.mrd;
      end else begin
        bif.mem_ack = 1'b0;
      end
      if (rdata_valid || write_done) begin
        done = 1'b1;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_empty: completion pulse with no expected entry at %0t", $time);
        end else begin
          got = sb_q.pop_front();
          check("pulse_cycle", 32'(cyc),          32'(got.lat));
          check("pulse_kind",  32'(write_done),   32'(got.md));
          check("pulse_excl",  32'(rdata_valid & write_done), 32'd0);
          check("bus_error",   32'(bus_error),    32'(got.err));
          check("req_cycles",  32'(req_n),        32'(got.req));
          check("done_busy",   32'(busy),         32'd1);
          check("done_memreq", 32'(bif.mem_req),  32'd0);
          check("done_rdata",  rdata,             got.rd);
        end
      end
      step();
      cyc++;
    end
    bif.mem_ack = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL no_completion: no pulse within 20 cycles for addr 0x%08h", v.a);
    end
    check("after_busy",   32'(busy),                      32'd0);
    check("after_pulse",  32'(rdata_valid | write_done),  32'd0);
    check("after_error",  32'(bus_error),                 32'd0);
    check("after_memreq", 32'(bif.mem_req),               32'd0);
    check("after_rdata",  rdata,                          rdata_model);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // mode, addr, wdata, waits, ack_en, mem_rdata, exp_err, exp_lat, exp_req
    vecs[0] = '{BUS_READ,  32'h0000_0010, 32'h0,         0, 1'b1, 32'h1234_5678, 1'b0, 2, 1};
    vecs[1] = '{BUS_WRITE, 32'h0000_0020, 32'hCAFE_F00D, 3, 1'b1, 32'h0,         1'b0, 5, 4};
    vecs[2] = '{BUS_READ,  32'h0000_0013, 32'h0,         0, 1'b1, 32'h5A5A_5A5A, 1'b1, 1, 0};
    vecs[3] = '{BUS_READ,  32'h0000_0040, 32'h0,         0, 1'b0, 32'hFFFF_FFFF, 1'b1, 6, 5};
    vecs[4] = '{BUS_READ,  32'h0000_0044, 32'h0,         2, 1'b1, 32'hA5A5_0001, 1'b0, 4, 3};
    vecs[5] = '{BUS_WRITE, 32'h0000_0022, 32'h1357_9BDF, 0, 1'b1, 32'h0,         1'b1, 1, 0};
    vecs[6] = '{BUS_WRITE, 32'h0000_0100, 32'h0F0F_0F0F, 4, 1'b1, 32'h0,         1'b0, 6, 5};
    vecs[7] = '{BUS_READ,  32'hFFFF_FFFC, 32'h0,         1, 1'b1, 32'hDEAD_BEEF, 1'b0, 3, 2};

    rst_n = 1'b0;
    start_transaction = 1'b0;
    mode  = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    bif.mem_ack   = 1'b0;
    bif.mem_rdata = 32'h0;
    rdata_model   = 32'h0;
    step();
    step();
    check("rst_rdata",       rdata,                  32'h0);
    check("rst_rdata_valid", 32'(rdata_valid),       32'd0);
    check("rst_write_done",  32'(write_done),        32'd0);
    check("rst_bus_error",   32'(bus_error),         32'd0);
    check("rst_busy",        32'(busy),              32'd0);
    check("rst_mem_req",     32'(bif.mem_req),       32'd0);
    check("rst_mem_we",      32'(bif.mem_we),        32'd0);
    check("rst_mem_addr",    bif.mem_addr,           32'h0);
    check("rst_mem_wdata",   bif.mem_wdata,          32'h0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) do_txn(vecs[i]);

    // Spurious ack in IDLE, then start held high through REQ and DONE.
    bif.mem_ack   = 1'b1;
    bif.mem_rdata = 32'hBAD0_BAD0;
    step();
    check("spur_busy",    32'(busy),        32'd0);
    check("spur_memreq",  32'(bif.mem_req), 32'd0);
    check("spur_pulse",   32'(rdata_valid), 32'd0);
    check("spur_rdata",   rdata,            rdata_model);
    bif.mem_ack = 1'b0;
    start_transaction = 1'b1;
    mode = BUS_READ;
    addr = 32'h0000_0050;
    step();
    check("b2b_c1_memreq", 32'(bif.mem_req), 32'd1);
    check("b2b_c1_addr",   bif.mem_addr,     32'h0000_0050);
    addr = 32'h0000_0060;
    bif.mem_ack   = 1'b1;
    bif.mem_rdata = 32'h1111_0001;
    step();
    check("b2b_c2_valid",  32'(rdata_valid), 32'd1);
    check("b2b_c2_rdata",  rdata,            32'h1111_0001);
    check("b2b_c2_memreq", 32'(bif.mem_req), 32'd0);
    check("b2b_c2_addr",   bif.mem_addr,     32'h0000_0050);
    step();
    check("b2b_c3_busy",   32'(busy),        32'd0);
    check("b2b_c3_valid",  32'(rdata_valid), 32'd0);
    check("b2b_c3_memreq", 32'(bif.mem_req), 32'd0);
    bif.mem_ack = 1'b0;
    step();
    check("b2b_c4_memreq", 32'(bif.mem_req), 32'd1);
    check("b2b_c4_addr",   bif.mem_addr,     32'h0000_0060);
    start_transaction = 1'b0;
    bif.mem_ack   = 1'b1;
    bif.mem_rdata = 32'h2222_0002;
    step();
    check("b2b_c5_valid",  32'(rdata_valid), 32'd1);
    check("b2b_c5_rdata",  rdata,            32'h2222_0002);
    bif.mem_ack = 1'b0;
    step();
    check("b2b_c6_valid",  32'(rdata_valid), 32'd0);
    check("b2b_c6_busy",   32'(busy),        32'd0);
    rdata_model = 32'h2222_0002;

    // Reset asserted in the second wait cycle of a write.
    start_transaction = 1'b1;
    mode  = BUS_WRITE;
    addr  = 32'h0000_0030;
    wdata = 32'h5555_AAAA;
    step();
    start_transaction = 1'b0;
    check("rstw_c1_memreq", 32'(bif.mem_req), 32'd1);
    step();
    check("rstw_c2_memreq", 32'(bif.mem_req), 32'd1);
    rst_n = 1'b0;
    step();
    check("rstw_memreq",  32'(bif.mem_req), 32'd0);
    check("rstw_busy",    32'(busy),        32'd0);
    check("rstw_mem_we",  32'(bif.mem_we),  32'd0);
    check("rstw_addr",    bif.mem_addr,     32'h0);
    check("rstw_wdata",   bif.mem_wdata,    32'h0);
    check("rstw_rdata",   rdata,            32'h0);
    rst_n = 1'b1;
    rdata_model = 32'h0;
    for (int i = 0; i < 3; i++) begin
      check("rstw_no_done", 32'(write_done), 32'd0);
      step();
    end
    do_txn('{BUS_READ, 32'h0000_0034, 32'h0, 1, 1'b1, 32'h0BAD_F00D, 1'b0, 3, 2});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_controller.md
# bus_controller

- Sits between the CPU control unit and the single-port word memory.
- Accepts one read or write request per handshake and drives the memory request/acknowledge protocol.
- Reports completion back to the control unit with a one-cycle `rdata_valid` or `write_done` pulse.
- Handles memory wait states, misaligned addresses and a configurable acknowledge timeout.

## Interface
Parameters:
- TIMEOUT, 255, maximum cycles in REQ without `mem_ack` before aborting; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset: one clock, synchronous, active-low.
- start_transaction  in  1  request strobe from the control unit; sampled only in IDLE.
- mode  in  1  0 = read, 1 = write; latched with start.
- addr  in  32  byte address; latched with start.
- wdata  in  32  write data; latched with start.
- rdata  out  32  read result; holds until the next read completes.
- rdata_valid  out  1  one-cycle pulse when a read completes (including error completion).
- write_done  out  1  one-cycle pulse when a write completes (including error completion).
- bus_error  out  1  high during the completion pulse cycle if the transaction was misaligned or timed out.
- busy  out  1  high in REQ and DONE.
- mem_req  out  1  memory request; held high until acknowledged.
- mem_we  out  1  memory write enable; valid while `mem_req` is high.
- mem_addr  out  32  word address `{addr[31:2], 2'b00}`.
- mem_wdata  out  32  latched write data.
- mem_ack  in  1  memory acknowledge; honoured only in REQ.
- mem_rdata  in  32  read data; valid in the cycle `mem_ack` is high.

## Operation
States: IDLE, REQ, DONE.

- **IDLE**
  - `busy` is 0 and all pulses are 0.
  - On a sampled `start_transaction` = 1, latch `mode`, `addr` and `wdata`.
  - If `addr[1:0]` != 0: go to DONE with the error flag set. No memory request is issued.
  - Otherwise: go to REQ and clear the wait counter.
- **REQ**
  - `mem_req` = 1; `mem_we`, `mem_addr` and `mem_wdata` come from the latched values and stay stable for the whole state.
  - On `mem_ack` = 1: if reading, load `rdata` from `mem_rdata`; go to DONE with the error flag clear.
  - Otherwise the wait counter increments. When it reaches TIMEOUT (TIMEOUT > 0), go to DONE with the error flag set.
  - On a read timeout, `rdata` is loaded with 32'h0000_0000.
- **DONE**
  - Assert `rdata_valid` (read) or `write_done` (write) for exactly one cycle.
  - `bus_error` equals the error flag during that cycle.
  - Return to IDLE.
- `start_transaction` while in REQ or DONE is ignored; it is not queued.
- `mem_ack` in IDLE or DONE is ignored.
- The wait counter is $clog2(TIMEOUT+1) bits wide and saturates; it never wraps.

## Timing
- Reset (`rst_n` = 0 at an edge) puts the block in IDLE. All outputs are 0 after that edge: `rdata` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- Reset mid-transaction drops `mem_req` at that same edge. No completion pulse follows.
- All outputs are registered or decoded from state only. No combinational path from `mem_ack` to any output.
- Zero-wait memory (`mem_ack` high in the first REQ cycle):
  - start sampled at edge 0;
  - REQ during cycle 1;
  - pulse during cycle 2;
  - IDLE during cycle 3, where the next start can be sampled.
- Each memory wait cycle adds one cycle to the latency.
- Misaligned access: start at edge 0, error pulse during cycle 1.
- Timeout: the error pulse occurs TIMEOUT+1 cycles after REQ is entered.
- Back-to-back throughput: at most one transaction per 3 cycles.

## Structure
- Shared package `cpu_bus_pkg` holds:
  - the state enum (IDLE/REQ/DONE);
  - `BUS_READ` = 1'b0 and `BUS_WRITE` = 1'b1;
  - the timeout error read value constant 32'h0000_0000.
- One sub-module is natural: `bus_wait_counter`, a clear/enable saturating counter with a terminal-count output, parameterised by TIMEOUT.
- Everything else is a single FSM plus the address, data and mode latches.

## Test plan
- Zero-wait read: addr 0x0000_0010, `mem_rdata` 0x1234_5678 → `mem_req` high for 1 cycle; `rdata_valid` pulse 2 cycles after the start edge; `rdata` = 0x1234_5678; `bus_error` = 0.
- Write with 3 wait cycles: addr 0x0000_0020, `wdata` 0xCAFE_F00D → `mem_we`, `mem_addr` and `mem_wdata` stable for 4 REQ cycles; `write_done` pulse 5 cycles after the start.
- Misaligned read at 0x0000_0013 → `mem_req` never asserts; `rdata_valid` and `bus_error` both pulse in cycle 1; `rdata` unchanged.
- TIMEOUT = 4 with `mem_ack` held low → `rdata_valid` and `bus_error` pulse in cycle 6; `rdata` = 0; `mem_req` low afterwards.
- `start_transaction` re-asserted during REQ and DONE, plus a spurious `mem_ack` in IDLE → exactly one completion pulse; the next start is accepted only in cycle 3.
- `rst_n` low during the second wait cycle of a write → `mem_req` = 0 after that edge; no `write_done`; a fresh read after reset completes normally.
